// File: rtl/quad_pkg.sv
// rtl/quad_pkg.sv - shared state, phase codes and Gray helper for the quadrature decoder
package quad_pkg;

  typedef enum logic {
    ST_INIT  = 1'b0,
    ST_TRACK = 1'b1
  } state_t;

  // Phase codes are {A,B}
  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_01 = 2'b01;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_10 = 2'b10;

  // Forward (count-up) neighbour in the sequence 00->01->11->10->00
  function automatic logic [1:0] gray_fwd(input logic [1:0] ph);
    logic [1:0] nxt;
    case (ph)
      PH_00:   nxt = PH_01;
      PH_01:   nxt = PH_11;
      PH_11:   nxt = PH_10;
      default: nxt = PH_00;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/quad_step_decoder_if.sv
// rtl/quad_step_decoder_if.sv - encoder pins, control strobes and decoded outputs
interface quad_step_decoder_if #(
  parameter int CNT_W = 16
);
  logic             a_in;
  logic             b_in;
  logic             clr;
  logic             err_clr;
  logic             dir;
  logic             step;
  logic [CNT_W-1:0] pos;
  logic             tc;
  logic             err;

  modport master (
    output a_in, b_in, clr, err_clr,
    input  dir, step, pos, tc, err
  );

  modport slave (
    input  a_in, b_in, clr, err_clr,
    output dir, step, pos, tc, err
  );
endinterface

// File: rtl/quad_filter.sv
// rtl/quad_filter.sv - per-channel synchroniser and consecutive-cycle glitch filter
module quad_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level
);

  localparam int CW = (FILT_LEN < 2) ? 1 : $clog2(FILT_LEN);

  logic [SYNC_STAGES-1:0] sync;
  logic                   sync_out;
  logic                   held;
  logic                   primed;
  logic [CW-1:0]          cnt;

  assign sync_out = sync[SYNC_STAGES-1];

  // Synchroniser chain is deliberately unreset so it already carries the pin
  // level when reset releases, letting the first held value match the pin.
  always_ff @(posedge clk) begin
    sync <= {sync[SYNC_STAGES-2:0], din};
  end

  // Held level: seeded from the synchroniser on the first cycle after reset,
  // then only changes after FILT_LEN consecutive differing cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held   <= 1'b0;
      primed <= 1'b0;
      cnt    <= '0;
    end else if (!primed) begin
      held   <= sync_out;
      primed <= 1'b1;
      cnt    <= '0;
    end else if (sync_out == held) begin
      cnt <= '0;
    end else if (cnt == CW'(FILT_LEN - 1)) begin
      held <= sync_out;
      cnt  <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  // Before seeding, pass the synchronised pin straight through so the
  // decoder's INIT cycle captures the real encoder position.
  assign level = primed ? held : sync_out;

endmodule

// File: rtl/quad_step_decoder.sv
// rtl/quad_step_decoder.sv - quadrature decoder: direction, step strobe, position, wrap and error
module quad_step_decoder
  import quad_pkg::*;
#(
  parameter int CNT_W       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 4
) (
  input logic               clk,
  input logic               rst,
  quad_step_decoder_if.slave bus
);

  logic             a_lvl, b_lvl;
  logic [1:0]       cur_ph;
  state_t           state, state_n;
  logic [1:0]       ref_ph, ref_n;
  logic             step_q, step_n;
  logic             tc_q, tc_n;
  logic             dir_q, dir_n;
  logic             err_q, err_n;
  logic [CNT_W-1:0] pos_q, pos_n;

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_a (
    .clk(clk), .rst(rst), .din(bus.a_in), .level(a_lvl)
  );

  quad_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_filt_b (
    .clk(clk), .rst(rst), .din(bus.b_in), .level(b_lvl)
  );

  assign cur_ph = {a_lvl, b_lvl};

  // State, reference phase and all registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_INIT;
      ref_ph <= PH_00;
      step_q <= 1'b0;
      tc_q   <= 1'b0;
      dir_q  <= 1'b1;
      err_q  <= 1'b0;
      pos_q  <= '0;
    end else begin
      state  <= state_n;
      ref_ph <= ref_n;
      step_q <= step_n;
      tc_q   <= tc_n;
      dir_q  <= dir_n;
      err_q  <= err_n;
      pos_q  <= pos_n;
    end
  end

  // Compare filtered phase with the reference and derive step/dir/pos/tc/err
  always_comb begin
    state_n = state;
    ref_n   = ref_ph;
    step_n  = 1'b0;
    tc_n    = 1'b0;
    dir_n   = dir_q;
    err_n   = err_q;
    pos_n   = pos_q;

    // Clear first so a coincident illegal transition still sets err
    if (bus.err_clr) err_n = 1'b0;

    case (state)
      ST_INIT: begin
        ref_n   = cur_ph;
        state_n = ST_TRACK;
      end
      default: begin
        ref_n = cur_ph;
        if (cur_ph == ref_ph) begin
          step_n = 1'b0;
        end else if (cur_ph == gray_fwd(ref_ph)) begin
          step_n = 1'b1;
          dir_n  = 1'b1;
          pos_n  = pos_q + CNT_W'(1);
          tc_n   = (pos_q == '1);
        end else if (ref_ph == gray_fwd(cur_ph)) begin
          step_n = 1'b1;
          dir_n  = 1'b0;
          pos_n  = pos_q - CNT_W'(1);
          tc_n   = (pos_q == '0);
        end else begin
          err_n = 1'b1;
        end
      end
    endcase

    // clr overrides the position update and masks the wrap strobe
    if (bus.clr) begin
      pos_n = '0;
      tc_n  = 1'b0;
    end
  end

  assign bus.step = step_q;
  assign bus.tc   = tc_q;
  assign bus.dir  = dir_q;
  assign bus.err  = err_q;
  assign bus.pos  = pos_q;

endmodule

// File: tb/tb_quad_step_decoder.sv
// tb/tb_quad_step_decoder.sv - directed self-checking bench for quad_step_decoder
module tb_quad_step_decoder;

  localparam int CNT_W = 16;
  localparam int SYNC_STAGES = 2;
  localparam int FILT_LEN = 4;
  // Edges from driving a pin (before the sampling edge) to the step strobe
  localparam int STEP_LAT = 1 + SYNC_STAGES + FILT_LEN;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad = 0;
  int   cyc = 0;
  int   step_total = 0;
  int   tc_total = 0;
  int   tc_bad = 0;
  int   step_long = 0;
  int   last_step_cyc = 0;
  logic prev_step = 1'b0;

  quad_step_decoder_if #(.CNT_W(CNT_W)) bus ();

  quad_step_decoder #(
    .CNT_W(CNT_W), .SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Strobe monitor sampled on the falling edge
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.step) begin
        step_total++;
        last_step_cyc = cyc;
      end
      if (bus.tc) tc_total++;
      if (bus.tc && !bus.step) tc_bad++;
      if (bus.step && prev_step) step_long++;
      prev_step = bus.step;
    end else begin
      prev_step = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", tag, got, want);
    end
  endtask

  task automatic pulse_clr();
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
  endtask

  // Drive a new pin level and check the resulting decode after it settles
  task automatic move(input string tag, input logic na, input logic nb, input int exp_steps,
                      input logic exp_dir, input logic [15:0] exp_pos, input int exp_tc);
    int s0, t0, c0;
    s0 = step_total;
    t0 = tc_total;
    c0 = cyc;
    bus.a_in = na;
    bus.b_in = nb;
    repeat (14) @(negedge clk);
    chk({tag, ".steps"}, step_total - s0, exp_steps);
    chk({tag, ".dir"}, bus.dir, exp_dir);
    chk({tag, ".pos"}, bus.pos, exp_pos);
    chk({tag, ".tc"}, tc_total - t0, exp_tc);
    if (exp_steps == 1) chk({tag, ".lat"}, last_step_cyc - c0, STEP_LAT);
  endtask

  // Toggle a_in for len cycles and let the filter settle
  task automatic pulse_a(input int len);
    bus.a_in = ~bus.a_in;
    repeat (len) @(negedge clk);
    bus.a_in = ~bus.a_in;
    repeat (24) @(negedge clk);
  endtask

  int s0, t0;

  initial begin
    rst = 1'b1;
    bus.a_in = 1'b1;
    bus.b_in = 1'b1;
    bus.clr = 1'b0;
    bus.err_clr = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst.pos", bus.pos, 16'h0);
    chk("rst.dir", bus.dir, 1'b1);
    chk("rst.step", bus.step, 1'b0);
    chk("rst.tc", bus.tc, 1'b0);
    chk("rst.err", bus.err, 1'b0);

    // 1: release with 11 on the pins -> no step, no error
    rst = 1'b0;
    repeat (12) @(negedge clk);
    chk("init.steps", step_total, 0);
    chk("init.err", bus.err, 1'b0);
    chk("init.pos", bus.pos, 16'h0);

    move("pre1", 1'b1, 1'b0, 1, 1'b1, 16'h0001, 0);
    move("pre2", 1'b0, 1'b0, 1, 1'b1, 16'h0002, 0);
    pulse_clr();
    chk("clr.pos", bus.pos, 16'h0);

    // 2: full forward cycle
    move("fwd01", 1'b0, 1'b1, 1, 1'b1, 16'h0001, 0);
    move("fwd11", 1'b1, 1'b1, 1, 1'b1, 16'h0002, 0);
    move("fwd10", 1'b1, 1'b0, 1, 1'b1, 16'h0003, 0);
    move("fwd00", 1'b0, 1'b0, 1, 1'b1, 16'h0004, 0);
    pulse_clr();

    // 3: wrap down then wrap up
    move("wrapdn", 1'b1, 1'b0, 1, 1'b0, 16'hFFFF, 1);
    move("wrapup", 1'b0, 1'b0, 1, 1'b1, 16'h0000, 1);

    // 4: glitch rejection from phase 01
    move("g01", 1'b0, 1'b1, 1, 1'b1, 16'h0001, 0);
    s0 = step_total;
    pulse_a(FILT_LEN - 1);
    chk("glitch3.steps", step_total - s0, 0);
    chk("glitch3.pos", bus.pos, 16'h0001);
    s0 = step_total;
    t0 = tc_total;
    pulse_a(FILT_LEN);
    chk("pulse4.steps", step_total - s0, 2);
    chk("pulse4.dir", bus.dir, 1'b0);
    chk("pulse4.pos", bus.pos, 16'h0001);
    chk("pulse4.tc", tc_total - t0, 0);

    // 5: illegal jumps and err_clr priority
    move("r00", 1'b0, 1'b0, 1, 1'b0, 16'h0000, 0);
    move("ill11", 1'b1, 1'b1, 0, 1'b0, 16'h0000, 0);
    chk("ill11.err", bus.err, 1'b1);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    chk("errclr.err", bus.err, 1'b0);
    move("r01", 1'b0, 1'b1, 1, 1'b0, 16'hFFFF, 1);
    s0 = step_total;
    bus.a_in = 1'b1;
    bus.b_in = 1'b0;
    repeat (STEP_LAT - 1) @(negedge clk);
    bus.err_clr = 1'b1;
    @(negedge clk);
    bus.err_clr = 1'b0;
    repeat (6) @(negedge clk);
    chk("setwins.err", bus.err, 1'b1);
    chk("setwins.steps", step_total - s0, 0);
    chk("setwins.pos", bus.pos, 16'hFFFF);

    // 6: clr coincident with a step at pos=7
    pulse_clr();
    move("c1", 1'b0, 1'b0, 1, 1'b1, 16'h0001, 0);
    move("c2", 1'b0, 1'b1, 1, 1'b1, 16'h0002, 0);
    move("c3", 1'b1, 1'b1, 1, 1'b1, 16'h0003, 0);
    move("c4", 1'b1, 1'b0, 1, 1'b1, 16'h0004, 0);
    move("c5", 1'b0, 1'b0, 1, 1'b1, 16'h0005, 0);
    move("c6", 1'b0, 1'b1, 1, 1'b1, 16'h0006, 0);
    move("c7", 1'b1, 1'b1, 1, 1'b1, 16'h0007, 0);
    t0 = tc_total;
    bus.a_in = 1'b1;
    bus.b_in = 1'b0;
    repeat (STEP_LAT - 1) @(negedge clk);
    bus.clr = 1'b1;
    @(negedge clk);
    bus.clr = 1'b0;
    chk("clrstep.step", bus.step, 1'b1);
    chk("clrstep.tc", bus.tc, 1'b0);
    chk("clrstep.pos", bus.pos, 16'h0000);
    chk("clrstep.dir", bus.dir, 1'b1);
    repeat (6) @(negedge clk);
    chk("clrstep.pos2", bus.pos, 16'h0000);
    chk("clrstep.tcn", tc_total - t0, 0);

    // Build up non-reset state, then reset mid-transition
    move("m1", 1'b0, 1'b0, 1, 1'b1, 16'h0001, 0);
    move("m2", 1'b1, 1'b1, 0, 1'b1, 16'h0001, 0);
    move("m3", 1'b0, 1'b1, 1, 1'b0, 16'h0000, 0);
    move("m4", 1'b0, 1'b0, 1, 1'b0, 16'hFFFF, 1);
    chk("m4.err", bus.err, 1'b1);
    bus.a_in = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst.pos", bus.pos, 16'h0);
    chk("midrst.dir", bus.dir, 1'b1);
    chk("midrst.err", bus.err, 1'b0);
    chk("midrst.step", bus.step, 1'b0);
    chk("midrst.tc", bus.tc, 1'b0);
    repeat (4) @(negedge clk);
    rst = 1'b0;
    s0 = step_total;
    repeat (14) @(negedge clk);
    chk("rel.steps", step_total - s0, 0);
    chk("rel.pos", bus.pos, 16'h0);
    chk("rel.err", bus.err, 1'b0);

    chk("strobe.tc_alone", tc_bad, 0);
    chk("strobe.step_long", step_long, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
